bf_stage_sched: RTL and testbench
=================================

// Module: bf_stage_sched
// PURPOSE
// - Per-stage NTT/INTT butterfly scheduler feeding the 256-bit butterfly unit (bf_256) and draining its results.
// - Issues coefficient-RAM pair reads and twiddle-ROM reads.
// - Asserts butterfly valid/sel aligned with read data.
// - Re-times write-back addresses/enables to match butterfly latency; pulses done after last write.
// - Gentleman-Sande order: for stage s, half = N>>(s+1); butterfly k -> j = k mod half, g = k / half.
// - addr_a = g*2*half + j, addr_b = addr_a + half, tw_addr = j << s (counters only, no divide).
// PARAMETERS
// LOGN     8  log2 of transform size N (N = 2^LOGN coefficients)
// RD_LAT   1  coefficient RAM / twiddle ROM read latency, cycles (>=1)
// BF_LAT   8  butterfly input-to-output latency, cycles (a_i/b_i/omg -> a_o/b_o)
// PORTS
// clk        in   1       clock, all logic on rising edge
// rst_n      in   1       synchronous active-low reset
// start      in   1       one-cycle request to run one stage
// stage      in   LOGN    stage index s, 0..LOGN-1, sampled with start
// mode       in   1       0 = NTT, 1 = INTT, sampled with start
// busy       out  1       high from accepted start through done
// done       out  1       one-cycle pulse after final write-back
// err        out  1       one-cycle pulse: start rejected (stage >= LOGN)
// rd_en      out  1       coefficient RAM read strobe
// rd_addr_a  out  LOGN    read address, upper-butterfly operand
// rd_addr_b  out  LOGN    read address, lower-butterfly operand
// tw_addr    out  LOGN-1  twiddle ROM address
// tw_inv     out  1       twiddle table select (= latched mode)
// bf_vld     out  1       butterfly operands valid this cycle (RD_LAT after rd_en)
// bf_sel     out  1       butterfly ntt/intt select (= latched mode while bf_vld)
// wr_en      out  1       write-back strobe for a_o/b_o (BF_LAT after bf_vld)
// wr_addr_a  out  LOGN    write address for a_o
// wr_addr_b  out  LOGN    write address for b_o
// BEHAVIOUR
// - Reset: all outputs 0; FSM -> IDLE; counters and delay lines cleared. Reset mid-stage aborts with no done pulse.
// - FSM IDLE:
//   - start && stage<LOGN: latch stage/mode; j=0, base=0; -> ISSUE; busy=1 next cycle.
//   - start && stage>=LOGN: err=1 for one cycle; stay IDLE.
// - FSM ISSUE: one butterfly per cycle, N/2 cycles total.
//   - rd_en=1, addresses per formula.
//   - j++; on j==half-1: j=0, base += 2*half.
//   - After butterfly N/2-1 issues -> DRAIN.
// - FSM DRAIN: rd_en=0; wait until last wr_en has been driven, then -> DONE.
// - FSM DONE: done=1, busy=0 for one cycle; -> IDLE.
// - start while busy: ignored, no err.
// - Delay line: depth RD_LAT+BF_LAT carries {valid, addr_a, addr_b}.
//   - bf_vld/bf_sel = tap RD_LAT.
//   - wr_en/wr_addr_* = tap RD_LAT+BF_LAT.
// - Stage s=LOGN-1 (half=1): tw_addr always 0. Stage 0: half=N/2, single group.
// - Total latency start -> done = 1 + N/2 + RD_LAT + BF_LAT cycles.
// - No flow control: the butterfly pipeline has no stall.
// CONFIGURATION
// BF_SCHED_PERF_EN defined:
//   - Adds output perf_cyc [31:0]: cycles from accepted start to done, inclusive.
//   - Value held until next accepted start; cleared by reset.
// BF_SCHED_PERF_EN undefined: perf_cyc port and counter absent; all other behaviour identical.
// TESTING
// - LOGN=3, start stage=0 mode=0 -> rd pairs (0,4)(1,5)(2,6)(3,7); tw 0,1,2,3; bf_sel=0.
// - LOGN=3, stage=2 mode=1 -> pairs (0,1)(2,3)(4,5)(6,7); tw 0,0,0,0; tw_inv=1; bf_sel=1.
// - RD_LAT=1, BF_LAT=8, stage=1 -> bf_vld 1 cycle after each rd_en; wr_en 8 cycles after bf_vld; same addrs.
// - LOGN=3, RD_LAT=1, BF_LAT=8: done 14 cycles after start.
// - start stage=3 with LOGN=3 -> err pulse 1 cycle, busy stays 0.
// - Second start mid-ISSUE -> ignored. rst_n=0 mid-DRAIN -> all outputs 0 next cycle, no done.

Source files
------------

// File: rtl/bf_stage_sched.sv
// rtl/bf_stage_sched.sv - per-stage NTT/INTT butterfly scheduler with write-back re-timing
//
// Purpose: runs one Gentleman-Sande stage. It issues N/2 coefficient pair
// reads and twiddle reads, one per cycle, raises bf_vld/bf_sel RD_LAT cycles
// later, and raises wr_en with the matching addresses RD_LAT+BF_LAT cycles
// after each read. done pulses one cycle after the last write-back.
//
// Parameters: LOGN (log2 N), RD_LAT (memory read latency), BF_LAT (butterfly latency)
// Ports:
//   clk, rst_n                 clock, synchronous active-low reset
//   start, stage, mode         stage request (stage/mode sampled with start)
//   busy, done, err            status: running, finished pulse, rejected-start pulse
//   rd_en, rd_addr_a/b         coefficient RAM pair read
//   tw_addr, tw_inv            twiddle ROM address and table select
//   bf_vld, bf_sel             butterfly operand valid and ntt/intt select
//   wr_en, wr_addr_a/b         write-back strobe and addresses
//   perf_cyc                   cycles from accepted start to done (BF_SCHED_PERF_EN only)
// Optional feature macro: BF_SCHED_PERF_EN

module bf_stage_sched #(
    parameter int LOGN   = 8,
    parameter int RD_LAT = 1,
    parameter int BF_LAT = 8
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic [LOGN-1:0] stage,
    input  logic            mode,
    output logic            busy,
    output logic            done,
    output logic            err,
    output logic            rd_en,
    output logic [LOGN-1:0] rd_addr_a,
    output logic [LOGN-1:0] rd_addr_b,
    output logic [LOGN-2:0] tw_addr,
    output logic            tw_inv,
    output logic            bf_vld,
    output logic            bf_sel,
    output logic            wr_en,
    output logic [LOGN-1:0] wr_addr_a,
    output logic [LOGN-1:0] wr_addr_b
`ifdef BF_SCHED_PERF_EN
    ,
    output logic [31:0]     perf_cyc
`endif
);

    localparam int D  = RD_LAT + BF_LAT;
    localparam int W  = 2 * LOGN + 1;
    localparam int DW = $clog2(D + 1);

    localparam logic [LOGN-1:0] LOGN_V     = LOGN'(LOGN);
    localparam logic [LOGN-1:0] HALF0      = {1'b1, {(LOGN-1){1'b0}}};
    localparam logic [LOGN-2:0] K_LAST     = '1;
    localparam logic [LOGN-2:0] J_ONE      = (LOGN-1)'(1);
    localparam logic [DW-1:0]   DRAIN_LAST = DW'(D - 1);
    localparam logic [DW-1:0]   CNT_ONE    = DW'(1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_DRAIN,
        S_DONE
    } state_t;

    state_t          state_q, state_d;
    logic [LOGN-1:0] stage_q, stage_d;
    logic            mode_q, mode_d;
    logic [LOGN-2:0] j_q, j_d;
    logic [LOGN-1:0] base_q, base_d;
    logic [LOGN-2:0] k_q, k_d;
    logic [DW-1:0]   cnt_q, cnt_d;
    logic            err_q, err_d;
    logic [W-1:0]    pipe_q [1:D];
    logic [W-1:0]    pipe_d [1:D];

    logic [LOGN-1:0] half;
    logic [LOGN-2:0] half_m1;
    logic            issuing;
    logic [LOGN-1:0] addr_a;
    logic [LOGN-1:0] addr_b;

    // half = N >> (s+1); j wraps at half-1, which for stage 0 is all ones.
    assign half    = HALF0 >> stage_q;
    assign half_m1 = half[LOGN-2:0] - J_ONE;
    assign issuing = (state_q == S_ISSUE);
    assign addr_a  = base_q + {1'b0, j_q};
    assign addr_b  = addr_a + half;

    always_comb begin
        state_d = state_q;
        stage_d = stage_q;
        mode_d  = mode_q;
        j_d     = j_q;
        base_d  = base_q;
        k_d     = k_q;
        cnt_d   = cnt_q;
        err_d   = 1'b0;

        // Tap k of the delay line holds what was issued k cycles ago.
        pipe_d[1] = {issuing, (issuing ? addr_a : '0), (issuing ? addr_b : '0)};
        for (int k = 2; k <= D; k++) begin
            pipe_d[k] = pipe_q[k-1];
        end

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    if (stage < LOGN_V) begin
                        stage_d = stage;
                        mode_d  = mode;
                        j_d     = '0;
                        base_d  = '0;
                        k_d     = '0;
                        state_d = S_ISSUE;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            S_ISSUE: begin
                k_d = k_q + J_ONE;
                if (j_q == half_m1) begin
                    j_d    = '0;
                    base_d = base_q + (half << 1);
                end else begin
                    j_d = j_q + J_ONE;
                end
                if (k_q == K_LAST) begin
                    cnt_d   = '0;
                    state_d = S_DRAIN;
                end
            end
            S_DRAIN: begin
                // The last read reaches the write-back tap D cycles after issue.
                cnt_d = cnt_q + CNT_ONE;
                if (cnt_q == DRAIN_LAST) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            stage_q <= '0;
            mode_q  <= 1'b0;
            j_q     <= '0;
            base_q  <= '0;
            k_q     <= '0;
            cnt_q   <= '0;
            err_q   <= 1'b0;
            for (int k = 1; k <= D; k++) begin
                pipe_q[k] <= '0;
            end
        end else begin
            state_q <= state_d;
            stage_q <= stage_d;
            mode_q  <= mode_d;
            j_q     <= j_d;
            base_q  <= base_d;
            k_q     <= k_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
            for (int k = 1; k <= D; k++) begin
                pipe_q[k] <= pipe_d[k];
            end
        end
    end

    assign busy      = (state_q == S_ISSUE) || (state_q == S_DRAIN);
    assign done      = (state_q == S_DONE);
    assign err       = err_q;
    assign rd_en     = issuing;
    assign rd_addr_a = issuing ? addr_a : '0;
    assign rd_addr_b = issuing ? addr_b : '0;
    assign tw_addr   = issuing ? (j_q << stage_q) : '0;
    assign tw_inv    = mode_q;
    assign bf_vld    = pipe_q[RD_LAT][W-1];
    assign bf_sel    = bf_vld & mode_q;
    assign wr_en     = pipe_q[D][W-1];
    assign wr_addr_a = pipe_q[D][2*LOGN-1:LOGN];
    assign wr_addr_b = pipe_q[D][LOGN-1:0];

`ifdef BF_SCHED_PERF_EN
    logic [31:0] perf_q, perf_d;

    // Counts the start cycle as 1, then every cycle through the done cycle.
    always_comb begin
        perf_d = perf_q;
        if (state_q == S_IDLE) begin
            if (start && (stage < LOGN_V)) begin
                perf_d = 32'd1;
            end
        end else begin
            perf_d = perf_q + 32'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            perf_q <= '0;
        end else begin
            perf_q <= perf_d;
        end
    end

    assign perf_cyc = perf_q;
`endif

endmodule

// File: tb/tb_bf_stage_sched.sv
// tb/tb_bf_stage_sched.sv - directed self-checking bench for bf_stage_sched (LOGN=3)

module tb_bf_stage_sched;

    localparam int LOGN = 3;
    localparam int NC   = 20;

    logic            clk = 1'b0;
    logic            rst_n;
    logic            start;
    logic [LOGN-1:0] stage;
    logic            mode;
    logic            busy, done, err, rd_en, tw_inv, bf_vld, bf_sel, wr_en;
    logic [LOGN-1:0] rd_addr_a, rd_addr_b, wr_addr_a, wr_addr_b;
    logic [LOGN-2:0] tw_addr;

    int errors = 0;
    int checks = 0;

    logic            lg_rd   [0:NC-1];
    logic [LOGN-1:0] lg_ra   [0:NC-1];
    logic [LOGN-1:0] lg_rb   [0:NC-1];
    logic [LOGN-2:0] lg_tw   [0:NC-1];
    logic            lg_inv  [0:NC-1];
    logic            lg_vld  [0:NC-1];
    logic            lg_sel  [0:NC-1];
    logic            lg_wr   [0:NC-1];
    logic [LOGN-1:0] lg_wa   [0:NC-1];
    logic [LOGN-1:0] lg_wb   [0:NC-1];
    logic            lg_done [0:NC-1];
    logic            lg_busy [0:NC-1];
    logic            lg_err  [0:NC-1];

    bf_stage_sched #(.LOGN(LOGN), .RD_LAT(1), .BF_LAT(8)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .stage     (stage),
        .mode      (mode),
        .busy      (busy),
        .done      (done),
        .err       (err),
        .rd_en     (rd_en),
        .rd_addr_a (rd_addr_a),
        .rd_addr_b (rd_addr_b),
        .tw_addr   (tw_addr),
        .tw_inv    (tw_inv),
        .bf_vld    (bf_vld),
        .bf_sel    (bf_sel),
        .wr_en     (wr_en),
        .wr_addr_a (wr_addr_a),
        .wr_addr_b (wr_addr_b)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Start a stage in cycle 0 and log outputs for cycles 1..NC-1.
    // If inj_c > 0, a second start with stage inj_s is raised after cycle inj_c.
    task automatic run_stage(input logic [LOGN-1:0] s, input logic m,
                             input int inj_c, input logic [LOGN-1:0] inj_s);
        stage = s;
        mode  = m;
        start = 1'b1;
        for (int c = 1; c < NC; c++) begin
            step();
            start = 1'b0;
            lg_rd[c]   = rd_en;     lg_ra[c]  = rd_addr_a; lg_rb[c] = rd_addr_b;
            lg_tw[c]   = tw_addr;   lg_inv[c] = tw_inv;
            lg_vld[c]  = bf_vld;    lg_sel[c] = bf_sel;
            lg_wr[c]   = wr_en;     lg_wa[c]  = wr_addr_a; lg_wb[c] = wr_addr_b;
            lg_done[c] = done;      lg_busy[c] = busy;     lg_err[c] = err;
            if (c == inj_c) begin
                start = 1'b1;
                stage = inj_s;
            end
        end
        start = 1'b0;
    endtask

    task automatic test_reset();
        logic [15:0] obs;
        rst_n = 1'b0;
        start = 1'b0;
        stage = '0;
        mode  = 1'b0;
        repeat (3) step();
        obs = {busy, done, err, rd_en, tw_inv, bf_vld, bf_sel, wr_en,
               rd_addr_a, rd_addr_b, tw_addr};
        checks++;
        if (obs !== 16'h0) begin
            errors++;
            $display("FAIL reset_outputs: got %h expected 0000", obs);
        end
        checks++;
        if ({wr_addr_a, wr_addr_b} !== 6'h0) begin
            errors++;
            $display("FAIL reset_wr_addr: got %h expected 00", {wr_addr_a, wr_addr_b});
        end
        rst_n = 1'b1;
        step();
    endtask

    task automatic test_ntt_stage0();
        logic [LOGN-1:0] ea;
        int nd;
        run_stage(3'd0, 1'b0, 0, 3'd0);
        for (int i = 0; i < 4; i++) begin
            ea = LOGN'(i);
            checks++;
            if ({lg_rd[1+i], lg_ra[1+i], lg_rb[1+i], lg_tw[1+i], lg_inv[1+i]}
                    !== {1'b1, ea, ea + 3'd4, ea[1:0], 1'b0}) begin
                errors++;
                $display("FAIL s0_read[%0d]: rd=%b a=%0d b=%0d tw=%0d inv=%b expected 1 %0d %0d %0d 0",
                         i, lg_rd[1+i], lg_ra[1+i], lg_rb[1+i], lg_tw[1+i], lg_inv[1+i],
                         ea, ea + 3'd4, ea[1:0]);
            end
            checks++;
            if ({lg_vld[2+i], lg_sel[2+i]} !== 2'b10) begin
                errors++;
                $display("FAIL s0_bf[%0d]: vld/sel=%b%b expected 10", i, lg_vld[2+i], lg_sel[2+i]);
            end
        end
        checks++;
        if (lg_rd[5] !== 1'b0) begin
            errors++;
            $display("FAIL s0_rd_stop: rd_en at cycle 5 = %b expected 0", lg_rd[5]);
        end
        nd = 0;
        for (int c = 1; c < NC; c++) nd += int'(lg_done[c]);
        checks++;
        if (lg_done[14] !== 1'b1 || nd != 1) begin
            errors++;
            $display("FAIL s0_done: done@14=%b pulses=%0d expected 1 and 1", lg_done[14], nd);
        end
        checks++;
        if ({lg_busy[1], lg_busy[13], lg_busy[14]} !== 3'b110) begin
            errors++;
            $display("FAIL s0_busy: busy@1,13,14=%b%b%b expected 110",
                     lg_busy[1], lg_busy[13], lg_busy[14]);
        end
    endtask

    task automatic test_intt_last_stage();
        logic [LOGN-1:0] ea;
        run_stage(3'd2, 1'b1, 0, 3'd0);
        for (int i = 0; i < 4; i++) begin
            ea = LOGN'(2 * i);
            checks++;
            if ({lg_rd[1+i], lg_ra[1+i], lg_rb[1+i], lg_tw[1+i], lg_inv[1+i]}
                    !== {1'b1, ea, ea + 3'd1, 2'd0, 1'b1}) begin
                errors++;
                $display("FAIL s2_read[%0d]: rd=%b a=%0d b=%0d tw=%0d inv=%b expected 1 %0d %0d 0 1",
                         i, lg_rd[1+i], lg_ra[1+i], lg_rb[1+i], lg_tw[1+i], lg_inv[1+i],
                         ea, ea + 3'd1);
            end
            checks++;
            if ({lg_vld[2+i], lg_sel[2+i]} !== 2'b11) begin
                errors++;
                $display("FAIL s2_bf[%0d]: vld/sel=%b%b expected 11", i, lg_vld[2+i], lg_sel[2+i]);
            end
        end
    endtask

    task automatic test_latency_stage1();
        logic [LOGN-1:0] ea [0:3];
        logic [1:0]      et [0:3];
        ea[0] = 3'd0; ea[1] = 3'd1; ea[2] = 3'd4; ea[3] = 3'd5;
        et[0] = 2'd0; et[1] = 2'd2; et[2] = 2'd0; et[3] = 2'd2;
        run_stage(3'd1, 1'b0, 0, 3'd0);
        for (int i = 0; i < 4; i++) begin
            checks++;
            if ({lg_ra[1+i], lg_rb[1+i], lg_tw[1+i]} !== {ea[i], ea[i] + 3'd2, et[i]}) begin
                errors++;
                $display("FAIL s1_read[%0d]: a=%0d b=%0d tw=%0d expected %0d %0d %0d",
                         i, lg_ra[1+i], lg_rb[1+i], lg_tw[1+i], ea[i], ea[i] + 3'd2, et[i]);
            end
            checks++;
            if ({lg_wr[10+i], lg_wa[10+i], lg_wb[10+i]} !== {1'b1, ea[i], ea[i] + 3'd2}) begin
                errors++;
                $display("FAIL s1_write[%0d]: wr=%b a=%0d b=%0d expected 1 %0d %0d",
                         i, lg_wr[10+i], lg_wa[10+i], lg_wb[10+i], ea[i], ea[i] + 3'd2);
            end
        end
        checks++;
        if ({lg_vld[1], lg_vld[2], lg_vld[6], lg_wr[9], lg_wr[14]} !== 5'b01000) begin
            errors++;
            $display("FAIL s1_edges: vld@1,2,6 wr@9,14 = %b%b%b%b%b expected 01000",
                     lg_vld[1], lg_vld[2], lg_vld[6], lg_wr[9], lg_wr[14]);
        end
    endtask

    task automatic test_err();
        stage = 3'd3;
        mode  = 1'b0;
        start = 1'b1;
        step();
        start = 1'b0;
        checks++;
        if ({err, busy, rd_en} !== 3'b100) begin
            errors++;
            $display("FAIL err_pulse: err/busy/rd=%b%b%b expected 100", err, busy, rd_en);
        end
        step();
        checks++;
        if ({err, busy, rd_en} !== 3'b000) begin
            errors++;
            $display("FAIL err_clear: err/busy/rd=%b%b%b expected 000", err, busy, rd_en);
        end
    endtask

    task automatic test_start_while_busy();
        int nerr, nrd, nd;
        run_stage(3'd0, 1'b0, 2, 3'd3);
        nerr = 0; nrd = 0; nd = 0;
        for (int c = 1; c < NC; c++) begin
            nerr += int'(lg_err[c]);
            nrd  += int'(lg_rd[c]);
            nd   += int'(lg_done[c]);
        end
        checks++;
        if (nerr != 0 || nrd != 4 || nd != 1 || lg_done[14] !== 1'b1) begin
            errors++;
            $display("FAIL busy_start: errs=%0d reads=%0d dones=%0d done@14=%b expected 0 4 1 1",
                     nerr, nrd, nd, lg_done[14]);
        end
    endtask

    task automatic test_back_to_back();
        run_stage(3'd2, 1'b0, 0, 3'd0);
        checks++;
        if ({lg_rd[1], lg_ra[1], lg_rb[1], lg_inv[1], lg_sel[2], lg_done[14]}
                !== {1'b1, 3'd0, 3'd1, 1'b0, 1'b0, 1'b1}) begin
            errors++;
            $display("FAIL b2b: rd=%b a=%0d b=%0d inv=%b sel=%b done=%b expected 1 0 1 0 0 1",
                     lg_rd[1], lg_ra[1], lg_rb[1], lg_inv[1], lg_sel[2], lg_done[14]);
        end
    endtask

    task automatic test_reset_mid_drain();
        logic [15:0] obs;
        int bad;
        stage = 3'd0;
        mode  = 1'b1;
        start = 1'b1;
        for (int c = 1; c <= 7; c++) begin
            step();
            start = 1'b0;
        end
        checks++;
        if ({busy, rd_en} !== 2'b10) begin
            errors++;
            $display("FAIL drain_state: busy/rd=%b%b expected 10", busy, rd_en);
        end
        rst_n = 1'b0;
        step();
        obs = {busy, done, err, rd_en, tw_inv, bf_vld, bf_sel, wr_en,
               rd_addr_a, rd_addr_b, tw_addr};
        checks++;
        if (obs !== 16'h0 || {wr_addr_a, wr_addr_b} !== 6'h0) begin
            errors++;
            $display("FAIL drain_reset: outs=%h wr_addr=%h expected 0000 00",
                     obs, {wr_addr_a, wr_addr_b});
        end
        rst_n = 1'b1;
        bad = 0;
        for (int c = 0; c < 15; c++) begin
            step();
            if (done || wr_en || busy) bad++;
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL drain_abort: %0d cycles with done/wr_en/busy expected 0", bad);
        end
    endtask

    initial begin
        test_reset();
        test_ntt_stage0();
        test_intt_last_stage();
        test_latency_stage1();
        test_err();
        test_start_while_busy();
        test_back_to_back();
        test_reset_mid_drain();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1);
    end

endmodule
